// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / result-out handshake bundle for alu_issue_ctrl.
// Latency: none, wires only.
// Backpressure: valid/ready on both the instruction and the result channel.
interface alu_issue_ctrl_if #(
  parameter int DW = 32
);
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_zf;
  logic [4:0]    res_rd;
  logic          branch_taken;

  // Instruction source / result sink side.
  modport master (
    output inst_valid, inst, res_ready,
    input  inst_ready, res_valid, res_data, res_zf, res_rd, branch_taken
  );

  // Controller side.
  modport slave (
    input  inst_valid, inst, res_ready,
    output inst_ready, res_valid, res_data, res_zf, res_rd, branch_taken
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around an external combinational 4-bit-opcode ALU.
// Latency: accept edge, one ALU settle cycle, result valid after the next edge.
// Backpressure: result held in RESP until res_ready; no new instruction accepted meanwhile.
// Optional build macro ALU_ILLEGAL_TRAP_EN adds the registered 'illegal' output.
module alu_issue_ctrl #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_ctrl_if.slave     bus,
  output logic [3:0]          alu_op,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  input  logic [31:0]         alu_res,
  input  logic                alu_zf,
  input  logic [4:0]          dbg_addr,
`ifdef ALU_ILLEGAL_TRAP_EN
  output logic                illegal,
`endif
  output logic [31:0]         dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rf [NREG];

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [DW-1:0] rs_val, rt_val;

  logic [3:0]    dec_op;
  logic [DW-1:0] dec_b;
  logic [4:0]    dec_dest;
  logic          dec_wb, dec_br, dec_ill;

  logic [4:0]    dest_q;
  logic          wb_q, br_q, ill_q;

  assign opcode = bus.inst[31:26];
  assign rs     = bus.inst[25:21];
  assign rt     = bus.inst[20:16];
  assign rd     = bus.inst[15:11];
  assign funct  = bus.inst[5:0];
  assign imm    = bus.inst[15:0];

  // Register 0 is hardwired to zero on every read port.
  assign rs_val   = (rs == 5'd0)       ? '0 : rf[rs];
  assign rt_val   = (rt == 5'd0)       ? '0 : rf[rt];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

  // Decode the offered instruction into ALU op, operand B, destination and flags.
  always_comb begin
    dec_op   = 4'b1111;
    dec_b    = '0;
    dec_dest = 5'd0;
    dec_wb   = 1'b0;
    dec_br   = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      6'b000000: begin
        dec_b    = rt_val;
        dec_dest = rd;
        dec_wb   = 1'b1;
        case (funct)
          6'b100100: dec_op = 4'b0000;
          6'b100101: dec_op = 4'b0001;
          6'b100000: dec_op = 4'b0010;
          6'b100010: dec_op = 4'b0110;
          6'b101010: dec_op = 4'b0111;
          6'b100111: dec_op = 4'b1100;
          default: begin
            dec_op   = 4'b1111;
            dec_b    = '0;
            dec_dest = 5'd0;
            dec_wb   = 1'b0;
            dec_ill  = 1'b1;
          end
        endcase
      end
      6'b001000: begin dec_op = 4'b0010; dec_b = {{(DW-16){imm[15]}}, imm}; dec_dest = rt; dec_wb = 1'b1; end
      6'b001010: begin dec_op = 4'b0111; dec_b = {{(DW-16){imm[15]}}, imm}; dec_dest = rt; dec_wb = 1'b1; end
      6'b001100: begin dec_op = 4'b0000; dec_b = {{(DW-16){1'b0}}, imm};    dec_dest = rt; dec_wb = 1'b1; end
      6'b001101: begin dec_op = 4'b0001; dec_b = {{(DW-16){1'b0}}, imm};    dec_dest = rt; dec_wb = 1'b1; end
      6'b000100: begin dec_op = 4'b0110; dec_b = rt_val; dec_br = 1'b1; end
      default:   dec_ill = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and the accept-side ready.
  always_comb begin
    state_d        = state_q;
    bus.inst_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.inst_ready = 1'b1;
        if (bus.inst_valid) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on accept, result capture after the ALU settles, handshake release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op           <= 4'b0000;
      alu_a            <= '0;
      alu_b            <= '0;
      dest_q           <= 5'd0;
      wb_q             <= 1'b0;
      br_q             <= 1'b0;
      ill_q            <= 1'b0;
      bus.res_valid    <= 1'b0;
      bus.res_data     <= '0;
      bus.res_zf       <= 1'b0;
      bus.res_rd       <= 5'd0;
      bus.branch_taken <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
      illegal          <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.inst_valid) begin
          alu_op <= dec_op;
          alu_a  <= rs_val;
          alu_b  <= dec_b;
          dest_q <= dec_dest;
          wb_q   <= dec_wb;
          br_q   <= dec_br;
          ill_q  <= dec_ill;
        end
        EXEC: begin
          bus.res_data     <= alu_res;
          bus.res_zf       <= alu_zf;
          bus.branch_taken <= br_q & alu_zf;
          bus.res_rd       <= wb_q ? dest_q : 5'd0;
          bus.res_valid    <= 1'b1;
`ifdef ALU_ILLEGAL_TRAP_EN
          illegal          <= ill_q;
`endif
        end
        RESP: if (bus.res_ready) bus.res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Register file: writeback happens on the result handshake, before the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (state_q == RESP && bus.res_ready && wb_q && dest_q != 5'd0) begin
      rf[dest_q] <= bus.res_data;
    end
  end

endmodule
